// File: rtl/gng_pkg.sv
// rtl/gng_pkg.sv - shared types for the gng sample scheduler
package gng_pkg;

  localparam int GNG_DATA_W = 16;
  // Tag id is sized for the largest supported requester count (16).
  localparam int GNG_ID_W = 4;

  typedef enum logic {IDLE, RUN} gng_sched_state_t;

  typedef struct packed {
    logic                vld;
    logic [GNG_ID_W-1:0] id;
    logic                last;
  } gng_tag_t;

endpackage

// File: rtl/gng_rr_arb.sv
// rtl/gng_rr_arb.sv - round-robin pick with registered search pointer
module gng_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic                     take,
  output logic                     any,
  output logic [$clog2(NREQ)-1:0]  win_id,
  output logic [NREQ-1:0]          win_oh
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr;

  always_comb begin
    int idx;
    idx    = 0;
    any    = 1'b0;
    win_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any    = 1'b1;
        win_id = IW'(idx);
      end
    end
    win_oh = NREQ'(1) << win_id;
  end

  // Next search starts just past the most recent winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;
    end
  end

endmodule

// File: rtl/gng_sched.sv
// rtl/gng_sched.sv - time-shares one gng noise core among NREQ burst requesters
module gng_sched
  import gng_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LENW    = 16,
  parameter int GNG_LAT = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*LENW-1:0]   req_len,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   gng_ce,
  input  logic                   gng_valid,
  input  logic [GNG_DATA_W-1:0]  gng_data,
  output logic [NREQ-1:0]        out_valid,
  output logic [GNG_DATA_W-1:0]  out_data,
  output logic                   err
);

  localparam int IW = $clog2(NREQ);

  gng_sched_state_t state;
  logic [LENW-1:0]  remaining;
  logic [IW-1:0]    owner;

  logic             arb_any;
  logic             arb_take;
  logic [IW-1:0]    arb_id;
  logic [NREQ-1:0]  arb_oh;
  logic [LENW-1:0]  sel_len;
  logic [LENW-1:0]  win_len;
  logic             last_ce;

  gng_tag_t         tag_pipe [GNG_LAT];
  gng_tag_t         tag_push;
  gng_tag_t         tag_head;
  logic [NREQ-1:0]  head_oh;

  // The current owner is masked so it cannot win its own re-arbitration.
  gng_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req & ~gnt),
    .take   (arb_take),
    .any    (arb_any),
    .win_id (arb_id),
    .win_oh (arb_oh)
  );

  assign last_ce  = (state == RUN) && (remaining == LENW'(1));
  assign arb_take = arb_any && ((state == IDLE) || last_ce);

  always_comb begin
    sel_len = req_len[int'(arb_id)*LENW +: LENW];
    win_len = (sel_len == '0) ? LENW'(1) : sel_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gng_ce    <= 1'b0;
      remaining <= '0;
      owner     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            state     <= RUN;
            gnt       <= arb_oh;
            owner     <= arb_id;
            remaining <= win_len;
            gng_ce    <= 1'b1;
          end
        end
        RUN: begin
          remaining <= remaining - 1'b1;
          if (last_ce) begin
            if (arb_any) begin
              gnt       <= arb_oh;
              owner     <= arb_id;
              remaining <= win_len;
            end else begin
              state  <= IDLE;
              gnt    <= '0;
              gng_ce <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tag_push.vld  = gng_ce;
    tag_push.id   = GNG_ID_W'(owner);
    tag_push.last = (remaining == LENW'(1));
  end

  // Tag entry written in ce cycle t reaches the head in cycle t+GNG_LAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < GNG_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= tag_push;
      for (int k = 1; k < GNG_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign tag_head = tag_pipe[GNG_LAT-1];
  assign head_oh  = NREQ'(1) << tag_head.id;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      done      <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= tag_head.vld ? head_oh : '0;
      done      <= (tag_head.vld && tag_head.last) ? head_oh : '0;
      out_data  <= gng_data;
      err       <= err | (gng_valid != tag_head.vld);
    end
  end

endmodule
